// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the status-flag bundle.
package alu_seq_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_MUL  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } flags_t;

    // zero/negative always come from the result itself, carry/overflow from the op
    function automatic flags_t make_flags(input logic res_zero, input logic res_msb,
                                          input logic carry, input logic overflow);
        flags_t f;
        f.zero     = res_zero;
        f.carry    = carry;
        f.negative = res_msb;
        f.overflow = overflow;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand-in / result-out handshake bundle between the controller, the ALU and the consumer.
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, carry, negative, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry, negative, overflow
    );

endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one multiplier bit per step, full 2*WIDTH product in the accumulator.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done_c
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [SHW-1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= PW'(a);
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
        end
    end

    // High while the step in flight consumes the last multiplier bit
    assign done_c  = step && (cnt == SHW'(WIDTH - 1));
    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides and registered result/flags.
// Define ALU_SEQ_MUL_EN to build in the multi-cycle shift-add multiplier (op 8).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] result_q;
    flags_t           flags_q;
    logic             valid_q;

    logic             accept;
    logic             load;
    logic             take;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    flags_t           flags_c;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_start;
    logic               mul_step;
    logic               mul_done_c;
    logic [2*WIDTH-1:0] mul_prod;

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .step    (mul_step),
        .a       (bus.a),
        .b       (bus.b),
        .product (mul_prod),
        .done_c  (mul_done_c)
    );
`endif

    assign bus.in_ready = (state_q == ST_IDLE);
    assign accept       = (state_q == ST_IDLE) && bus.in_valid;
    // First DONE cycle registers the result; out_valid follows one edge later
    assign load         = (state_q == ST_DONE) && !valid_q;
    assign take         = valid_q && bus.out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and multiplier control
    always_comb begin
        state_d = state_q;
`ifdef ALU_SEQ_MUL_EN
        mul_start = 1'b0;
        mul_step  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (bus.op == OP_MUL) begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_done_c) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (take) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are frozen at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (accept) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            op_q <= bus.op;
        end
    end

    assign sum_c  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_c = {1'b0, a_q} - {1'b0, b_q};
    assign shamt  = b_q[SHW-1:0];

    // Single-cycle datapath; undefined opcodes fall through to zero
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = diff_c[WIDTH-1:0];
                carry_c = diff_c[WIDTH];
                ovf_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  res_c = a_q & b_q;
            OP_OR:   res_c = a_q | b_q;
            OP_SLTU: res_c = WIDTH'(diff_c[WIDTH]);
            OP_XOR:  res_c = a_q ^ b_q;
            OP_SHL:  res_c = a_q << shamt;
            OP_SHR:  res_c = a_q >> shamt;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                res_c   = mul_prod[WIDTH-1:0];
                carry_c = |mul_prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
    end

    assign flags_c = make_flags(res_c == '0, res_c[WIDTH-1], carry_c, ovf_c);

    // Result and flags hold until the next load, including under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            result_q <= res_c;
            flags_q  <= flags_c;
            valid_q  <= 1'b1;
        end else if (take) begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = flags_q.zero;
    assign bus.carry     = flags_q.carry;
    assign bus.negative  = flags_q.negative;
    assign bus.overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table plus backpressure and reset-mid-op sequences.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned WIDTH = 8;

`ifdef ALU_SEQ_MUL_EN
    localparam int MUL_LAT = WIDTH + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       n;
        logic       v;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] r, input logic z, input logic c,
                                input logic n, input logic v, input int lat);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.res = r;
        t.z = z; t.c = c; t.n = n; t.v = v; t.lat = lat;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string nm, input logic [7:0] exp_res);
        check($sformatf("%s in_ready", nm), 32'(bus.in_ready), 32'd1);
        check($sformatf("%s out_valid", nm), 32'(bus.out_valid), 32'd0);
        check($sformatf("%s result", nm), 32'(bus.result), 32'(exp_res));
    endtask

    // Offer one op; operands are scrambled right after the accept edge
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        check("in_ready before issue", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = op ^ 4'h1;
        bus.a  = ~a;
        bus.b  = ~b;
    endtask

    // Counts clock edges after the accept edge until out_valid, bounded
    task automatic wait_valid(input string nm, input int exp_lat);
        int n = 0;
        bit rdy = 1'b0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            if (bus.in_ready !== 1'b0) rdy = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b0) rdy = 1'b1;
        check($sformatf("%s latency", nm), 32'(n), 32'(exp_lat));
        check($sformatf("%s in_ready while busy", nm), 32'(rdy), 32'd0);
    endtask

    task automatic check_result(input string nm, input vec_t v);
        check($sformatf("%s result", nm), 32'(bus.result), 32'(v.res));
        check($sformatf("%s flags zcnv", nm),
              32'({bus.zero, bus.carry, bus.negative, bus.overflow}),
              32'({v.z, v.c, v.n, v.v}));
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        bus.out_ready = 1'b1;
        issue(v.op, v.a, v.b);
        wait_valid(nm, v.lat);
        check_result(nm, v);
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs($sformatf("%s after take", nm), v.res);
    endtask

    initial begin
        bit   stable;
        bit   rdy;
        bit   ov_seen;
        vec_t t;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset", 8'h00);
        check("reset flags", 32'({bus.zero, bus.carry, bus.negative, bus.overflow}), 32'd0);
        rst = 1'b0;

        //              op       a      b      res    z     c     n     v     lat
        vecs.push_back(mk(OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(OP_SLTU, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SLTU, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1));
        vecs.push_back(mk(OP_ADD,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1));
        vecs.push_back(mk(OP_SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_OR,   8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_XOR,  8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SHL,  8'h01, 8'h08, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SHR,  8'h80, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd12,   8'h55, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd15,   8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1));
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back(mk(OP_MUL,  8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, MUL_LAT));
        vecs.push_back(mk(OP_MUL,  8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, MUL_LAT));
        vecs.push_back(mk(OP_MUL,  8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, MUL_LAT));
`else
        vecs.push_back(mk(OP_MUL,  8'h10, 8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, MUL_LAT));
        vecs.push_back(mk(OP_MUL,  8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, MUL_LAT));
`endif
        vecs.push_back(mk(OP_MUL,  8'h00, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, MUL_LAT));

        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held, competing offer ignored, in_ready returns after take
        bus.out_ready = 1'b0;
        issue(OP_SHL, 8'h81, 8'h09);
        wait_valid("bp", 1);
        stable = 1'b1;
        rdy    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op = OP_ADD;
            bus.a  = 8'h01;
            bus.b  = 8'h01;
            if (bus.result !== 8'h02 || bus.out_valid !== 1'b1 ||
                {bus.zero, bus.carry, bus.negative, bus.overflow} !== 4'b0000) stable = 1'b0;
            if (bus.in_ready !== 1'b0) rdy = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("bp held stable", 32'(stable), 32'd1);
        check("bp in_ready during stall", 32'(rdy), 32'd0);
        check("bp result", 32'(bus.result), 32'h02);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("bp after take", 8'h02);

        // Reset mid-MUL (or in DONE when the multiplier is not built)
        t = mk(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        run_vec("pre-rst", t);
        bus.out_ready = 1'b0;
        issue(OP_MUL, 8'h0F, 8'h0F);
        ov_seen = bus.out_valid;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
            if (bus.out_valid !== 1'b0) ov_seen = 1'b1;
`endif
        end
`ifdef ALU_SEQ_MUL_EN
        check("rst mid-mul out_valid never", 32'(ov_seen), 32'd0);
        check("rst mid-mul result untouched", 32'(bus.result), 32'h80);
`endif
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = OP_ADD;
        bus.a  = 8'h09;
        bus.b  = 8'h09;
        #1;
        check_idle_outputs("rst async", 8'h00);
        check("rst async flags", 32'({bus.zero, bus.carry, bus.negative, bus.overflow}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("post-rst idle", 8'h00);

        t = mk(OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_vec("post-rst add", t);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
